// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder backed by a byte-writable block RAM of 32-bit words.
// It supports programmable wait states, the two-cycle ERROR response, and write-to-read bypass.
module ahb_sram_responder #(
  parameter int AWID        = 12,
  parameter int DEPTH       = 768,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ahb_s0_haddr_i,
  input  logic        ahb_s0_hwrite_i,
  input  logic [2:0]  ahb_s0_hsize_i,
  input  logic [2:0]  ahb_s0_hburst_i,
  input  logic [3:0]  ahb_s0_hprot_i,
  input  logic [1:0]  ahb_s0_htrans_i,
  input  logic        ahb_s0_hmastlock_i,
  input  logic [31:0] ahb_s0_hwdata_i,
  output logic        ahb_s0_hready_o,
  output logic        ahb_s0_hresp_o,
  output logic [31:0] ahb_s0_hrdata_o
);

  localparam int IW = AWID - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic            dph_q, dph_d;
  logic            d_wr_q, d_wr_d;
  logic [IW-1:0]   d_idx_q, d_idx_d;
  logic [3:0]      d_be_q, d_be_d;
  logic            zero_q, zero_d;
  logic [3:0]      byp_be_q, byp_be_d;
  logic [31:0]     byp_data_q, byp_data_d;
  logic [31:0]     ram_rd_q;
  logic [31:0]     mem [DEPTH];

  logic [IW-1:0]   a_idx;
  logic [1:0]      a_lo;
  logic [3:0]      a_be;
  logic            accept, illegal, commit, rd_en;
  logic [31:0]     merged;

  logic unused_ok;
  assign unused_ok = ^{ahb_s0_haddr_i[31:AWID], ahb_s0_hburst_i, ahb_s0_hprot_i,
                       ahb_s0_hmastlock_i, ahb_s0_htrans_i[0]};

  assign a_idx = ahb_s0_haddr_i[AWID-1:2];
  assign a_lo  = ahb_s0_haddr_i[1:0];

  assign ahb_s0_hready_o = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign ahb_s0_hresp_o  = (state_q == S_ERR1) || (state_q == S_ERR2);

  assign accept  = ahb_s0_hready_o && ahb_s0_htrans_i[1];
  assign illegal = (ahb_s0_hsize_i > 3'd2) ||
                   ((ahb_s0_hsize_i == 3'd1) && a_lo[0]) ||
                   ((ahb_s0_hsize_i == 3'd2) && (a_lo != 2'd0)) ||
                   (32'(a_idx) >= 32'(DEPTH));
  // A legal data phase ends (and a write lands) on any edge seen in IDLE with a phase open.
  assign commit  = dph_q && d_wr_q && (state_q == S_IDLE);
  assign rd_en   = accept && !illegal && !ahb_s0_hwrite_i;

  always_comb begin
    case (ahb_s0_hsize_i[1:0])
      2'd0:    a_be = 4'b0001 << a_lo;
      2'd1:    a_be = a_lo[1] ? 4'b1100 : 4'b0011;
      default: a_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dph_d      = dph_q;
    d_wr_d     = d_wr_q;
    d_idx_d    = d_idx_q;
    d_be_d     = d_be_q;
    zero_d     = zero_q;
    byp_be_d   = byp_be_q;
    byp_data_d = byp_data_q;
    case (state_q)
      S_WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = S_IDLE;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        dph_d   = 1'b0;
        state_d = S_IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = S_ERR1;
            zero_d  = 1'b1;
          end else begin
            dph_d   = 1'b1;
            d_wr_d  = ahb_s0_hwrite_i;
            d_idx_d = a_idx;
            d_be_d  = a_be;
            if (!ahb_s0_hwrite_i) zero_d = 1'b0;
            if (WAIT_STATES != 0) begin
              state_d = S_WAIT;
              wcnt_d  = 3'(WAIT_STATES);
            end
          end
        end
      end
    endcase
    // The RAM read on this edge misses a write landing on the same edge, so keep its lanes aside.
    if (rd_en) begin
      byp_be_d   = (commit && (d_idx_q == a_idx)) ? d_be_q : 4'b0000;
      byp_data_d = ahb_s0_hwdata_i;
    end
  end

  always_comb begin
    merged = ram_rd_q;
    for (int b = 0; b < 4; b++)
      if (byp_be_q[b]) merged[8*b +: 8] = byp_data_q[8*b +: 8];
  end

  assign ahb_s0_hrdata_o = zero_q ? 32'd0 : merged;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 3'd0;
      dph_q      <= 1'b0;
      d_wr_q     <= 1'b0;
      d_idx_q    <= '0;
      d_be_q     <= 4'b0000;
      zero_q     <= 1'b1;
      byp_be_q   <= 4'b0000;
      byp_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dph_q      <= dph_d;
      d_wr_q     <= d_wr_d;
      d_idx_q    <= d_idx_d;
      d_be_q     <= d_be_d;
      zero_q     <= zero_d;
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
    end
  end

  // RAM array: no reset so contents survive; a reset edge drops the pending write.
  always_ff @(posedge clk) begin
    if (commit && !reset)
      for (int b = 0; b < 4; b++)
        if (d_be_q[b]) mem[d_idx_q][8*b +: 8] <= ahb_s0_hwdata_i[8*b +: 8];
    if (rd_en) ram_rd_q <= mem[a_idx];
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: zero-wait and three-wait instances share one bus.
// A byte-array model feeds a scoreboard queue that a negedge monitor drains.
module tb_ahb_sram_responder;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans;
  logic        hmastlock = 1'b0;
  logic        hready0, hresp0, hready3, hresp3;
  logic [31:0] hrdata0, hrdata3;
  bit          act;

  always #5 clk = ~clk;

  ahb_sram_responder #(.AWID(12), .DEPTH(768), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite),
    .ahb_s0_hsize_i(hsize), .ahb_s0_hburst_i(hburst), .ahb_s0_hprot_i(hprot),
    .ahb_s0_htrans_i(htrans), .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
    .ahb_s0_hready_o(hready0), .ahb_s0_hresp_o(hresp0), .ahb_s0_hrdata_o(hrdata0));

  ahb_sram_responder #(.AWID(12), .DEPTH(768), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst3), .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite),
    .ahb_s0_hsize_i(hsize), .ahb_s0_hburst_i(hburst), .ahb_s0_hprot_i(hprot),
    .ahb_s0_htrans_i(htrans), .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
    .ahb_s0_hready_o(hready3), .ahb_s0_hresp_o(hresp3), .ahb_s0_hrdata_o(hrdata3));

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t     sbq[$];
  bit [7:0] mdl [2][4096];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (dut%0d): got %h expected %h", name, act ? 3 : 0, got, want);
    end
  endtask

  // One AHB transfer: hold the address phase until accepted, then drive its write data.
  task automatic issue(input bit w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit apply);
    bit          rdy;
    int          g;
    exp_t        e;
    bit          ill;
    logic [11:0] off;
    int          nb;
    haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
    g = 0;
    do begin
      @(negedge clk);
      rdy = act ? hready3 : hready0;
      @(posedge clk); #1;
      g++;
    end while (!rdy && g < 64);
    htrans = 2'b00;
    if (!rdy) begin
      chk("accept_timeout", 32'(rdy), 32'd1);
      return;
    end
    off = a[11:0];
    ill = (sz > 3'd2) || (sz == 3'd1 && off[0]) || (sz == 3'd2 && off[1:0] != 2'd0) ||
          (off[11:2] >= 10'd768);
    e.rd = !w; e.err = ill; e.rdata = 32'd0;
    e.waits = ill ? 1 : (act ? 3 : 0);
    hwdata = $urandom;
    if (!ill) begin
      if (w) begin
        hwdata = wd;
        if (apply) begin
          nb = 1 << sz;
          for (int k = 0; k < nb; k++) begin
            logic [11:0] ba;
            ba = off + 12'(k);
            mdl[act][ba] = wd[8*ba[1:0] +: 8];
          end
        end
      end else begin
        e.rdata = {mdl[act][{off[11:2], 2'd3}], mdl[act][{off[11:2], 2'd2}],
                   mdl[act][{off[11:2], 2'd1}], mdl[act][{off[11:2], 2'd0}]};
      end
    end
    sbq.push_back(e);
  endtask

  task automatic gap(input logic [1:0] tr);
    htrans = tr;
    @(posedge clk); #1;
    htrans = 2'b00;
  endtask

  task automatic rand_op();
    int          r;
    logic [2:0]  sz;
    logic [9:0]  idx;
    logic [1:0]  lo;
    logic [31:0] a, rnd;
    r = $urandom_range(0, 99);
    if (r < 8) begin
      gap(r < 4 ? 2'b00 : 2'b01);
      return;
    end
    sz  = 3'($urandom_range(0, 2));
    idx = 10'($urandom_range(0, 63));
    rnd = $urandom;
    lo  = (sz == 3'd0) ? rnd[1:0] : (sz == 3'd1) ? {rnd[1], 1'b0} : 2'd0;
    if (r < 16) lo = rnd[3:2];
    if (r >= 16 && r < 20) idx = 10'($urandom_range(768, 1023));
    if (r == 20 || r == 21) sz = 3'($urandom_range(3, 7));
    a = $urandom;
    a[11:0] = {idx, lo};
    issue(1'($urandom_range(0, 1)), sz, a, $urandom, 1'b1);
  endtask

  task automatic init_words();
    for (int i = 0; i < 64; i++) issue(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b1);
  endtask

  // Monitor: tracks accepted data phases on the bus and scores each completion.
  int inph = 0, lowcnt = 0, lowerr = 0;
  always @(negedge clk) begin
    logic        r, p, ra;
    logic [31:0] d;
    exp_t        e;
    r  = act ? hready3 : hready0;
    p  = act ? hresp3 : hresp0;
    d  = act ? hrdata3 : hrdata0;
    ra = act ? rst3 : rst0;
    if (ra) begin
      inph = 0; lowcnt = 0; lowerr = 0;
      sbq.delete();
    end else begin
      if (inph != 0 && !r) begin
        lowcnt++;
        if (p) lowerr++;
      end else if (inph != 0) begin
        if (sbq.size() == 0) chk("unexpected_dphase", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("hresp", 32'(p), 32'(e.err));
          chk("wait_cycles", 32'(lowcnt), 32'(e.waits));
          chk("err_first_cycle", 32'(lowerr), e.err ? 32'd1 : 32'd0);
          if (e.rd || e.err) chk("hrdata", d, e.rdata);
        end
        inph = 0;
      end else begin
        chk("idle_ready_resp", {30'd0, r, p}, 32'd2);
      end
      if (r && htrans[1]) begin
        inph = 1; lowcnt = 0; lowerr = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst3 = 1'b1; act = 1'b0;
    haddr = 32'd0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b00; hwdata = 32'd0;

    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("reset_hready", 32'(hready0), 32'd1);
      chk("reset_hresp", 32'(hresp0), 32'd0);
      chk("reset_hrdata", hrdata0, 32'd0);
    end
    @(posedge clk); #1 rst0 = 1'b0;

    init_words();
    issue(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 1'b1);
    gap(2'b00);
    issue(1'b0, 3'd2, 32'h010, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h020, 32'h11223344, 1'b1);
    issue(1'b1, 3'd0, 32'h021, 32'h0000AA00, 1'b1);
    issue(1'b1, 3'd1, 32'h022, 32'hBBCC0000, 1'b1);
    issue(1'b0, 3'd2, 32'h020, 32'd0, 1'b1);
    issue(1'b0, 3'd0, 32'h023, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h030, 32'h12345678, 1'b1);
    issue(1'b0, 3'd2, 32'h030, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'hFFFF_FC00, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h002, 32'h00000055, 1'b1);
    gap(2'b01);
    issue(1'b0, 3'd2, 32'h000, 32'd0, 1'b1);
    for (int i = 0; i < 200; i++) rand_op();
    repeat (4) begin @(posedge clk); #1; end

    rst0 = 1'b1; act = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    init_words();
    issue(1'b0, 3'd2, 32'h040, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h040, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1 rst3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    @(negedge clk);
    chk("abort_hready", 32'(hready3), 32'd1);
    chk("abort_hresp", 32'(hresp3), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 3'd2, 32'h040, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h044, 32'hA5A5_5A5A, 1'b1);
    issue(1'b0, 3'd2, 32'h044, 32'd0, 1'b1);
    for (int i = 0; i < 60; i++) rand_op();
    repeat (8) begin @(posedge clk); #1; end

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
